// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register plus a fixed internal ROM, one fetch per clock.
// Optional IFU_PC_OUT_EN exposes the PC register on output port pc.
module instr_fetch_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] I,
  output logic [DATA_W-1:0] instruct
`ifdef IFU_PC_OUT_EN
  ,
  output logic [ADDR_W-1:0] pc
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instruct_q, instruct_d;
  logic [DATA_W-1:0] rom [DEPTH];

  // Constant ROM: every word is tagged 0xA000 with its own address in the low bits.
  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign rom[a] = DATA_W'(16'hA000) | DATA_W'(a);
  end

  // Only the low ADDR_W bits of the stride matter; the rest are deliberately dropped.
  logic unused_stride_hi;
  assign unused_stride_hi = ^I[DATA_W-1:ADDR_W];

  always_comb begin
    instruct_d = rom[pc_q];
    pc_d       = pc_q + I[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= '0;
      instruct_q <= '0;
    end else begin
      pc_q       <= pc_d;
      instruct_q <= instruct_d;
    end
  end

  assign instruct = instruct_q;

`ifdef IFU_PC_OUT_EN
  assign pc = pc_q;
`else
  // PC stays internal.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random strides and resets,
// compared against an address-level model of the fetch sequence.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] I;
  logic [15:0] instruct;
`ifdef IFU_PC_OUT_EN
  logic [7:0]  pc;
`endif

  instr_fetch_unit #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .I        (I),
    .instruct (instruct)
`ifdef IFU_PC_OUT_EN
    ,
    .pc       (pc)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_checks;
  int          n_errors;
  int          model_pc;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Address-level model: fetched word is 0xA000 | address; next address is (pc + stride) mod 256.
  task automatic model_edge();
    if (!rst) begin
      exp_q.push_back(16'h0000);
      model_pc = 0;
    end else begin
      exp_q.push_back(16'hA000 | 16'(model_pc));
      model_pc = (model_pc + (int'(I) % 256)) % 256;
    end
  endtask

  // One clock: model the edge, then compare just after it.
  task automatic fetch_edge(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_eq(tag, 32'(instruct), 32'(exp_q.pop_front()));
`ifdef IFU_PC_OUT_EN
    check_eq({tag, "_pc"}, 32'(pc), 32'(model_pc));
`endif
  endtask

  // Asynchronous reset assertion a little after the falling edge, checked before the next rising edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_pc = 0;
    #1;
    check_eq(tag, 32'(instruct), 32'h0);
`ifdef IFU_PC_OUT_EN
    check_eq({tag, "_pc"}, 32'(pc), 32'h0);
`endif
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq(tag, 32'(instruct), 32'h0);
  endtask

  task automatic restart(input logic [15:0] stride);
    async_reset("rst_clear");
    I = stride;
    fetch_edge("rst_hold");
    release_reset("rel_noglitch");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] seq3 [4];
    n_checks = 0;
    n_errors = 0;
    model_pc = 0;
    rst      = 1'b1;
    I        = 16'h0003;
    seq3     = '{16'hA000, 16'hA003, 16'hA006, 16'hA009};

    // Async reset while clk is low, then held for 3 edges with I=3.
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_init", 32'(instruct), 32'h0);
    for (int k = 0; k < 3; k++) fetch_edge("rst_hold3");

    // Release, stride 3.
    release_reset("rel_noglitch");
    for (int k = 0; k < 4; k++) begin
      fetch_edge("stride3");
      check_eq("stride3_lit", 32'(instruct), 32'(seq3[k]));
    end

    // Stride 1 through the whole ROM and past the wrap.
    restart(16'h0001);
    for (int k = 0; k < 258; k++) begin
      fetch_edge("stride1");
      check_eq("stride1_lit", 32'(instruct), 32'(16'hA000 | 16'(k % 256)));
    end

    // Stride 0 after reaching PC=5: same word refetched.
    restart(16'h0001);
    for (int k = 0; k < 5; k++) fetch_edge("to_pc5");
    I = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      fetch_edge("stride0");
      check_eq("stride0_lit", 32'(instruct), 32'hA005);
    end

    // Upper stride bits ignored.
    restart(16'h0103);
    for (int k = 0; k < 3; k++) begin
      fetch_edge("stride103");
      check_eq("stride103_lit", 32'(instruct), 32'(seq3[k]));
    end

    // Mid-run reset at PC=9.
    restart(16'h0003);
    for (int k = 0; k < 3; k++) fetch_edge("to_pc9");
`ifdef IFU_PC_OUT_EN
    check_eq("pc9", 32'(pc), 32'd9);
`endif
    async_reset("midrun_clear");
    fetch_edge("midrun_hold");
    release_reset("midrun_rel");
    fetch_edge("midrun_first");
    check_eq("midrun_first_lit", 32'(instruct), 32'hA000);
`ifdef IFU_PC_OUT_EN
    check_eq("midrun_pc3", 32'(pc), 32'd3);
`endif

    // Random strides with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      I = 16'($urandom_range(0, 16'hFFFF));
      if (rst && $urandom_range(0, 99) < 4) begin
        async_reset("rand_clear");
      end else if (!rst && $urandom_range(0, 99) < 50) begin
        release_reset("rand_rel");
      end
      fetch_edge("rand");
    end

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
